uart_frame_parser: RTL

- Consumes the 8N1 receiver's byte stream (8-bit data plus a one-cycle valid strobe) and extracts checksummed command frames.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Payload is buffered internally. A frame is released to the command logic only after the checksum passes, then held until acknowledged.
- Sits between the UART receiver and the command/register-access logic.

---
 rtl/uart_frame_parser.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/CMD/LEN/payload/CHK frames from a UART byte stream, buffers the payload
// and holds a checksum-good frame until the consumer acknowledges it.
module uart_frame_parser #(
   parameter int unsigned CLK_FREQ     = 25_000_000,
   parameter int unsigned BAUD_RATE    = 115_200,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_BITS = 20,
   localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1),
   localparam int unsigned ADDR_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_data,
   input  logic              i_valid,
   output logic              o_pkt_valid,
   output logic [7:0]        o_cmd,
   output logic [LEN_W-1:0]  o_len,
   input  logic              i_pkt_ack,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data,
   output logic              o_err_chk,
   output logic              o_err_len,
   output logic              o_err_timeout,
   output logic              o_err_drop,
   output logic [7:0]        o_err_count
);

   localparam int unsigned TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
   localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

   state_t           state_q;
   logic [7:0]       cmd_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx_q;
   logic [7:0]       sum_q;
   logic [TO_W-1:0]  tcnt_q;
   logic [7:0]       mem [2**ADDR_W];

   logic counting;
   assign counting = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHK);

   // Payload storage has no reset; contents are undefined until written.
   always_ff @(posedge i_clk) begin
      if (state_q == S_PAYLOAD && i_valid) begin
         mem[idx_q[ADDR_W-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= S_HUNT;
         cmd_q         <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         sum_q         <= '0;
         tcnt_q        <= '0;
         o_pkt_valid   <= 1'b0;
         o_cmd         <= '0;
         o_len         <= '0;
         o_rd_data     <= '0;
         o_err_chk     <= 1'b0;
         o_err_len     <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_drop    <= 1'b0;
         o_err_count   <= '0;
      end else begin
         o_err_chk     <= 1'b0;
         o_err_len     <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_drop    <= 1'b0;
         o_rd_data     <= mem[i_rd_addr];

         if ((o_err_chk || o_err_len || o_err_timeout || o_err_drop) && o_err_count != 8'hFF) begin
            o_err_count <= o_err_count + 8'd1;
         end

         unique case (state_q)
            S_HUNT: begin
               if (i_valid && i_data == SYNC_BYTE) state_q <= S_CMD;
            end
            S_CMD: begin
               if (i_valid) begin
                  cmd_q   <= i_data;
                  sum_q   <= i_data;
                  state_q <= S_LEN;
               end
            end
            S_LEN: begin
               if (i_valid) begin
                  sum_q <= sum_q + i_data;
                  idx_q <= '0;
                  len_q <= i_data[LEN_W-1:0];
                  if (32'(i_data) > MAX_LEN) begin
                     o_err_len <= 1'b1;
                     state_q   <= S_HUNT;
                  end else if (i_data == 8'd0) begin
                     state_q <= S_CHK;
                  end else begin
                     state_q <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (i_valid) begin
                  sum_q <= sum_q + i_data;
                  idx_q <= idx_q + LEN_W'(1);
                  if (idx_q + LEN_W'(1) == len_q) state_q <= S_CHK;
               end
            end
            S_CHK: begin
               if (i_valid) begin
                  if (8'(sum_q + i_data) == 8'h00) begin
                     o_pkt_valid <= 1'b1;
                     o_cmd       <= cmd_q;
                     o_len       <= len_q;
                     state_q     <= S_HOLD;
                  end else begin
                     o_err_chk <= 1'b1;
                     state_q   <= S_HUNT;
                  end
               end
            end
            S_HOLD: begin
               // Ack wins over a same-cycle byte, which is then treated as hunt input.
               if (i_pkt_ack) begin
                  o_pkt_valid <= 1'b0;
                  state_q     <= (i_valid && i_data == SYNC_BYTE) ? S_CMD : S_HUNT;
               end else if (i_valid) begin
                  o_err_drop <= 1'b1;
               end
            end
            default: state_q <= S_HUNT;
         endcase

         if (i_valid || !counting) begin
            tcnt_q <= '0;
         end else if (tcnt_q == TO_LAST) begin
            tcnt_q        <= '0;
            o_err_timeout <= 1'b1;
            state_q       <= S_HUNT;
         end else begin
            tcnt_q <= tcnt_q + TO_W'(1);
         end
      end
   end

endmodule
